// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM request/response path.
// Used by the cache-side master, the CDC FIFO width settings and dram_app_adapter.
//   ADDR_W / DATA_W : MIG app address and data widths (one line = one app beat)
//   dram_req_t      : request FIFO word {we, addr, data}
//   APP_CMD_*       : MIG native app_cmd encodings
package dram_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = DATA_W / 8;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dram_req_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdCmd,
    StRdWait,
    StRsp
  } app_state_e;

endpackage

// File: rtl/dram_app_adapter.sv
// DRAM-side consumer of the request/response CDC FIFOs, running on the MIG ui_clk.
// Pops one line request at a time from a first-word-fall-through FIFO, issues it on the
// MIG native app interface and, for reads, pushes the returned line into the response FIFO.
// Exactly one transaction is outstanding at any time.
// Ports:
//   clk, rstn             : ui_clk, synchronous active-low reset
//   init_calib_complete   : gates new pops only
//   req / req_en / req_rdy: request FIFO head, not-empty, pop strobe
//   rsp / rsp_en / rsp_rdy: response line, write strobe, FIFO not-full
//   app_*                 : MIG native app command, write-data and read-data channels
//   err_rd                : sticky, read data arrived when none was expected
module dram_app_adapter
  import dram_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              init_calib_complete,
  input  dram_req_t         req,
  input  logic              req_en,
  output logic              req_rdy,
  output logic [DATA_W-1:0] rsp,
  output logic              rsp_en,
  input  logic              rsp_rdy,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  input  logic              app_rd_data_end,
  output logic              err_rd
);

  app_state_e        state_q, state_d;
  dram_req_t         cmd_q, cmd_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              cmd_done_q, cmd_done_d;
  logic              wdf_done_q, wdf_done_d;
  logic              err_rd_q, err_rd_d;
  logic              cmd_hs, wdf_hs;

  // A line is a single beat, so the end-of-burst flag carries no information.
  logic unused_rd_end;
  assign unused_rd_end = app_rd_data_end;

  // Strobes are gated by rstn so they read 0 during the reset cycle itself,
  // before the state register has been forced back to idle.
  assign req_rdy      = rstn && (state_q == StIdle) && req_en && init_calib_complete;
  assign app_en       = rstn && (((state_q == StWrite) && !cmd_done_q) || (state_q == StRdCmd));
  assign app_wdf_wren = rstn && (state_q == StWrite) && !wdf_done_q;
  assign app_wdf_end  = app_wdf_wren;
  assign rsp_en       = rstn && (state_q == StRsp) && rsp_rdy;

  assign cmd_hs = app_en && app_rdy;
  assign wdf_hs = app_wdf_wren && app_wdf_rdy;

  assign app_addr     = cmd_q.addr;
  assign app_cmd      = cmd_q.we ? APP_CMD_WR : APP_CMD_RD;
  assign app_wdf_data = cmd_q.data;
  assign app_wdf_mask = '0;
  assign rsp          = rsp_q;
  assign err_rd       = err_rd_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rsp_d      = rsp_q;
    cmd_done_d = cmd_done_q;
    wdf_done_d = wdf_done_q;
    // Data outside the read-wait window is dropped; remember that it happened.
    err_rd_d   = err_rd_q || (app_rd_data_valid && (state_q != StRdWait));

    case (state_q)
      StIdle: begin
        if (req_rdy) begin
          cmd_d      = req;
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
          state_d    = req.we ? StWrite : StRdCmd;
        end
      end
      StWrite: begin
        // Command and data channels handshake independently; leave once both have.
        if ((cmd_done_q || cmd_hs) && (wdf_done_q || wdf_hs)) begin
          cmd_done_d = 1'b0;
          wdf_done_d = 1'b0;
          state_d    = StIdle;
        end else begin
          cmd_done_d = cmd_done_q || cmd_hs;
          wdf_done_d = wdf_done_q || wdf_hs;
        end
      end
      StRdCmd: begin
        if (cmd_hs) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (app_rd_data_valid) begin
          rsp_d   = app_rd_data;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      rsp_q      <= '0;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
      err_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rsp_q      <= rsp_d;
      cmd_done_q <= cmd_done_d;
      wdf_done_q <= wdf_done_d;
      err_rd_q   <= err_rd_d;
    end
  end

endmodule

// File: tb/tb_dram_app_adapter.sv
// Bench for dram_app_adapter. Plays the request FIFO, the MIG app interface (with a line
// memory and read latency) and the response FIFO. A transaction-level model tracks the one
// outstanding request and predicts every strobe each cycle; read data is predicted from a
// reference memory updated in request order.
module tb_dram_app_adapter;
  import dram_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic              init_calib_complete;
  dram_req_t         req;
  logic              req_en;
  logic              req_rdy;
  logic [DATA_W-1:0] rsp;
  logic              rsp_en;
  logic              rsp_rdy;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              err_rd;

  always #5 clk = ~clk;

  dram_app_adapter dut (
    .clk                (clk),
    .rstn               (rstn),
    .init_calib_complete(init_calib_complete),
    .req                (req),
    .req_en             (req_en),
    .req_rdy            (req_rdy),
    .rsp                (rsp),
    .rsp_en             (rsp_en),
    .rsp_rdy            (rsp_rdy),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_rdy            (app_rdy),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_mask       (app_wdf_mask),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data        (app_rd_data),
    .app_rd_data_valid  (app_rd_data_valid),
    .app_rd_data_end    (app_rd_data_end),
    .err_rd             (err_rd)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus knobs (percent chance of ready / calibrated each cycle).
  int unsigned rdy_pct, wdf_pct, rsp_pct, calib_pct, lat_min, lat_max;
  bit          rst_val;
  bit          spur;

  // Request FIFO contents, expected responses, reference and DRAM memories.
  dram_req_t         req_q[$];
  logic [DATA_W-1:0] exp_rsp[$];
  logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] dram_mem[logic [ADDR_W-1:0]];

  // Transaction-level view of the adapter.
  bit                busy, cmd_acc, wdf_acc, rsp_pending, err_exp;
  dram_req_t         cur;
  int                rd_left = -1;
  logic [ADDR_W-1:0] rd_addr;
  int                pops = 0, rsps = 0, cyc = 0, obs_pop_cyc = 0, obs_rsp_cyc = 0;

  function automatic logic [DATA_W-1:0] init_line(input logic [ADDR_W-1:0] a);
    return {4{5'h15, a}};
  endfunction

  function automatic logic [DATA_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [DATA_W-1:0] dram_rd(input logic [ADDR_W-1:0] a);
    if (dram_mem.exists(a)) return dram_mem[a];
    return init_line(a);
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ref_mem[a]  = d;
    dram_mem[a] = d;
  endtask

  task automatic enq_rd(input logic [ADDR_W-1:0] a);
    dram_req_t r;
    r.we   = 1'b0;
    r.addr = a;
    r.data = rand_line();
    req_q.push_back(r);
    exp_rsp.push_back(ref_rd(a));
  endtask

  task automatic enq_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    dram_req_t r;
    r.we   = 1'b1;
    r.addr = a;
    r.data = d;
    req_q.push_back(r);
    ref_mem[a] = d;
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, then advance the
  // model across the rising edge.
  task automatic step();
    bit rd_ret, awaiting, e_req_rdy, e_app_en, e_wren, e_rsp_en;
    @(negedge clk);
    cyc++;
    rd_ret = 1'b0;
    if (rd_left > 0) begin
      rd_left--;
      if (rd_left == 0) begin
        rd_ret  = 1'b1;
        rd_left = -1;
      end
    end
    rstn                = rst_val;
    req_en              = (req_q.size() != 0);
    req                 = req_en ? req_q[0] : '0;
    init_calib_complete = ($urandom_range(99) < calib_pct);
    app_rdy             = ($urandom_range(99) < rdy_pct);
    app_wdf_rdy         = ($urandom_range(99) < wdf_pct);
    rsp_rdy             = ($urandom_range(99) < rsp_pct);
    app_rd_data_valid   = rd_ret || spur;
    app_rd_data_end     = app_rd_data_valid;
    app_rd_data         = rd_ret ? dram_rd(rd_addr) : rand_line();
    #1;
    awaiting  = busy && !cur.we && cmd_acc && !rsp_pending;
    e_req_rdy = rstn && req_en && init_calib_complete && !busy;
    e_app_en  = rstn && busy && !cmd_acc;
    e_wren    = rstn && busy && cur.we && !wdf_acc;
    e_rsp_en  = rstn && rsp_pending && rsp_rdy;

    chk("req_rdy", req_rdy, e_req_rdy);
    chk("app_en", app_en, e_app_en);
    chk("app_wdf_wren", app_wdf_wren, e_wren);
    chk("app_wdf_end", app_wdf_end, e_wren);
    chk("app_wdf_mask", app_wdf_mask, '0);
    chk("rsp_en", rsp_en, e_rsp_en);
    chk("err_rd", err_rd, err_exp);
    if (e_app_en) begin
      chk("app_addr", app_addr, cur.addr);
      chk("app_cmd", app_cmd, cur.we ? APP_CMD_WR : APP_CMD_RD);
    end
    if (e_wren) chk("app_wdf_data", app_wdf_data, cur.data);
    if (e_rsp_en) begin
      chk("rsp_queue_nonempty", exp_rsp.size() != 0, 1'b1);
      if (exp_rsp.size() != 0) chk("rsp_data", rsp, exp_rsp[0]);
    end
    if (req_rdy) obs_pop_cyc = cyc;
    if (rsp_en)  obs_rsp_cyc = cyc;

    @(posedge clk);
    if (!rstn) begin
      if (busy && !cur.we && exp_rsp.size() != 0) void'(exp_rsp.pop_front());
      busy        = 1'b0;
      cmd_acc     = 1'b0;
      wdf_acc     = 1'b0;
      rsp_pending = 1'b0;
      err_exp     = 1'b0;
    end else begin
      if (app_rd_data_valid) begin
        if (awaiting && rd_ret) rsp_pending = 1'b1;
        else                    err_exp     = 1'b1;
      end
      if (e_rsp_en) begin
        void'(exp_rsp.pop_front());
        rsps++;
        busy        = 1'b0;
        rsp_pending = 1'b0;
      end
      if (busy && cur.we) begin
        cmd_acc = cmd_acc || (e_app_en && app_rdy);
        wdf_acc = wdf_acc || (e_wren && app_wdf_rdy);
        if (cmd_acc && wdf_acc) begin
          dram_mem[cur.addr] = cur.data;
          busy = 1'b0;
        end
      end else if (busy && e_app_en && app_rdy) begin
        cmd_acc = 1'b1;
        rd_left = int'($urandom_range(lat_max, lat_min));
        rd_addr = cur.addr;
      end
      if (e_req_rdy) begin
        cur     = req_q.pop_front();
        pops++;
        busy    = 1'b1;
        cmd_acc = 1'b0;
        wdf_acc = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((busy || req_q.size() != 0 || rd_left >= 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", busy || req_q.size() != 0 || rd_left >= 0, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, n;
    logic [DATA_W-1:0] wd;
    rstn = 1'b0; rst_val = 1'b0; init_calib_complete = 1'b0; req = '0; req_en = 1'b0;
    rsp_rdy = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0; spur = 1'b0;
    rdy_pct = 100; wdf_pct = 100; rsp_pct = 100; calib_pct = 100; lat_min = 1; lat_max = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp", rsp, '0);
    chk("reset_app_addr", app_addr, '0);
    chk("reset_wdf_data", app_wdf_data, '0);
    chk("reset_err_rd", err_rd, 1'b0);

    // Strobes stay low in reset even with a request waiting and calibration done.
    enq_rd(27'h7);
    repeat (3) step();
    // Calibration gate.
    rst_val = 1'b1; calib_pct = 0;
    repeat (20) step();
    chk("calib_no_pop", pops, 0);
    calib_pct = 100;
    drain(50);
    chk("calib_pop_after", pops, 1);
    chk("calib_rsp_after", rsps, 1);

    // Single read, 8-cycle latency.
    set_mem(27'h123, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    lat_min = 8; lat_max = 8; p0 = pops; r0 = rsps;
    enq_rd(27'h123);
    drain(100);
    chk("rd_one_pop", pops - p0, 1);
    chk("rd_one_rsp", rsps - r0, 1);
    chk("rd_line", rsp, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    chk("rd_pop_to_rsp", obs_rsp_cyc - obs_pop_cyc, 10);

    // Write with data channel held off for 3 cycles.
    wd = rand_line(); r0 = rsps; wdf_pct = 0;
    enq_wr(27'h40, wd);
    n = 0;
    while (!busy && n < 10) begin step(); n++; end
    chk("wr_popped", busy, 1'b1);
    repeat (3) step();
    chk("wr_cmd_first", cmd_acc, 1'b1);
    chk("wr_data_pending", wdf_acc, 1'b0);
    wdf_pct = 100;
    step();
    chk("wr_done", busy, 1'b0);
    chk("wr_mem", dram_rd(27'h40), wd);
    repeat (2) step();
    chk("wr_no_rsp", rsps, r0);

    // Back-to-back reads with the response FIFO full.
    set_mem(27'h200, rand_line());
    set_mem(27'h201, rand_line());
    lat_min = 3; lat_max = 3; rsp_pct = 0; p0 = pops; r0 = rsps;
    enq_rd(27'h200);
    enq_rd(27'h201);
    n = 0;
    while (!rsp_pending && n < 30) begin step(); n++; end
    chk("bp_first_ready", rsp_pending, 1'b1);
    repeat (10) step();
    chk("bp_single_pop", pops - p0, 1);
    chk("bp_no_rsp", rsps - r0, 0);
    rsp_pct = 100;
    drain(60);
    chk("bp_two_pops", pops - p0, 2);
    chk("bp_two_rsps", rsps - r0, 2);

    // Spurious read data while idle.
    r0 = rsps; spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (4) step();
    chk("spur_err", err_rd, 1'b1);
    chk("spur_no_rsp", rsps, r0);

    // Reset during the read-wait window, data returns afterwards.
    lat_min = 8; lat_max = 8;
    enq_rd(27'h55);
    n = 0;
    while (!(busy && cmd_acc) && n < 20) begin step(); n++; end
    chk("mid_rst_cmd", cmd_acc, 1'b1);
    repeat (2) step();
    rst_val = 1'b0;
    repeat (2) step();
    rst_val = 1'b1;
    step();
    chk("mid_rst_rsp", rsp, '0);
    chk("mid_rst_addr", app_addr, '0);
    chk("mid_rst_err_clr", err_rd, 1'b0);
    n = 0;
    while (rd_left >= 0 && n < 20) begin step(); n++; end
    step();
    chk("late_err", err_rd, 1'b1);
    lat_min = 2; lat_max = 2; r0 = rsps; p0 = pops;
    enq_rd(27'h66);
    drain(50);
    chk("after_rst_rd", rsps - r0, 1);
    chk("no_repop", pops - p0, 1);

    // Randomised mix over a small address window to hit read-after-write.
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        rdy_pct   = $urandom_range(100, 40);
        wdf_pct   = $urandom_range(100, 40);
        rsp_pct   = $urandom_range(100, 30);
        calib_pct = $urandom_range(100, 60);
        lat_min   = $urandom_range(4, 1);
        lat_max   = lat_min + $urandom_range(6);
      end
      if ($urandom_range(2) == 0) enq_wr(27'($urandom_range(15)), rand_line());
      else                        enq_rd(27'($urandom_range(15)));
      repeat ($urandom_range(3)) step();
    end
    calib_pct = 100;
    drain(20000);
    chk("rand_rsp_all", exp_rsp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
